gate_tt_checker: RTL and testbench

Self-test sequencer for 2-input primitive gates. Drives the four input combinations into a gate-under-test (e.g. `gate_nand`), waits a programmable settle time, samples the gate output, and compares it against an expected truth table. It accumulates a per-vector failure mask and a failure count. It is the in-hardware counterpart of the primitive testbenches and sits directly around one primitive: it feeds that primitive's inputs and consumes its output.

---
 rtl/gate_tt_checker_pkg.sv | 22 ++
 rtl/gate_tt_checker_if.sv | 30 +++
 rtl/gate_tt_checker_settle_cnt.sv | 41 ++++
 rtl/gate_tt_checker.sv | 120 ++++++++++++
 tb/tb_gate_tt_checker.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/gate_tt_checker_pkg.sv
// Shared definitions for the 2-input gate truth-table checker.
// Holds the sequencer state encoding, the expected truth tables of the
// common primitives (bit idx = {b,a}), and the settle-counter width.
package gate_tt_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_XNOR = 4'b1001;

    localparam int CNT_W = 4;

endpackage

// File: rtl/gate_tt_checker_if.sv
// Bundle between the checker and its surroundings: run control/status and
// the connection to the gate under test.
//   start      : begin a run (sampled only when idle or done)
//   dut_s      : output of the gate under test
//   dut_a/b    : gate inputs driven by the checker
//   busy/done  : run status, pass = done with no mismatches
//   fail_count : number of mismatching vectors (0..4)
//   fail_mask  : bit idx set if vector idx = {b,a} mismatched
// slave  = checker side, master = environment side.
interface gate_tt_checker_if;
    logic       start;
    logic       dut_s;
    logic       dut_a;
    logic       dut_b;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] fail_count;
    logic [3:0] fail_mask;

    modport slave (
        input  start, dut_s,
        output dut_a, dut_b, busy, done, pass, fail_count, fail_mask
    );

    modport master (
        output start, dut_s,
        input  dut_a, dut_b, busy, done, pass, fail_count, fail_mask
    );
endinterface

// File: rtl/gate_tt_checker_settle_cnt.sv
// Settle-time counter for the gate checker.
// 4-bit up-counter with synchronous clear (clear wins over enable).
//   clk, reset : clock, synchronous active-high reset
//   clr        : force count to 0 at the next edge
//   en         : increment at the next edge
//   cnt        : current count
//   last       : count has reached SETTLE-1
module tt_settle_cnt
    import gate_tt_checker_pkg::*;
#(
    parameter int SETTLE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt  = cnt_q;
    assign last = (cnt_q == CNT_W'(SETTLE - 1));

endmodule

// File: rtl/gate_tt_checker.sv
// Self-test sequencer for a 2-input primitive gate.
// Walks idx = {b,a} through 0..3, holds each vector SETTLE cycles, samples
// the gate output in a one-cycle CHECK state and accumulates a per-vector
// failure mask and count against the EXPECT truth table.
//   clk, reset : clock, synchronous active-high reset
//   bus        : gate_tt_checker_if.slave (control, status, gate pins)
// All outputs come from flops; nothing depends combinationally on dut_s.
module gate_tt_checker
    import gate_tt_checker_pkg::*;
#(
    parameter int         SETTLE = 4,
    parameter logic [3:0] EXPECT = TT_NAND
) (
    input  logic               clk,
    input  logic               reset,
    gate_tt_checker_if.slave   bus
);

    if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
        $error("gate_tt_checker: SETTLE must be in 1..15");
    end

    state_e     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [2:0] fail_count_q, fail_count_d;
    logic [3:0] fail_mask_q, fail_mask_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;

    logic [CNT_W-1:0] cnt;
    logic             cnt_last;
    logic             mismatch;

    // Counter runs only in SETTLE and restarts from 0 for every vector;
    // clearing on the last count leaves it at 0 through CHECK.
    tt_settle_cnt #(.SETTLE(SETTLE)) u_settle_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   ((state_q != ST_SETTLE) || cnt_last),
        .en    (1'b1),
        .cnt   (cnt),
        .last  (cnt_last)
    );

    // Case inequality so an X/Z gate output is a mismatch in simulation.
    assign mismatch = (bus.dut_s !== EXPECT[idx_q]);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        fail_count_d = fail_count_q;
        fail_mask_d  = fail_mask_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d      = ST_SETTLE;
                    idx_d        = 2'd0;
                    fail_count_d = '0;
                    fail_mask_d  = '0;
                end
            end
            ST_SETTLE: begin
                if (cnt_last)
                    state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (mismatch) begin
                    fail_mask_d[idx_q] = 1'b1;
                    fail_count_d       = fail_count_q + 3'd1;
                end
                if (idx_q == 2'd3)
                    state_d = ST_DONE;
                else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = ST_SETTLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_SETTLE) || (state_d == ST_CHECK);
        done_d = (state_d == ST_DONE);
        pass_d = (state_d == ST_DONE) && (fail_count_d == 3'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= 2'd0;
            fail_count_q <= '0;
            fail_mask_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            fail_count_q <= fail_count_d;
            fail_mask_q  <= fail_mask_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
        end
    end

    // idx is 0 in IDLE and 3 in DONE, so the pins follow it directly.
    assign bus.dut_a      = idx_q[0];
    assign bus.dut_b      = idx_q[1];
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.fail_count = fail_count_q;
    assign bus.fail_mask  = fail_mask_q;

    logic unused_cnt;
    assign unused_cnt = ^cnt;

endmodule

// File: tb/tb_gate_tt_checker.sv
// Bench for gate_tt_checker: two instances (SETTLE=4/NAND, SETTLE=1/XOR),
// each looped back to a truth-table gate model, checked every cycle against
// a run-time based behavioural model plus directed literal expectations.
module tb_gate_tt_checker;
    import gate_tt_checker_pkg::*;

    localparam int         S0 = 4;
    localparam int         S1 = 1;
    localparam logic [3:0] E0 = TT_NAND;
    localparam logic [3:0] E1 = TT_XOR;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    gate_tt_checker_if i0 ();
    gate_tt_checker_if i1 ();

    logic [3:0] tt0, tt1;
    assign i0.dut_s = tt0[{i0.dut_b, i0.dut_a}];
    assign i1.dut_s = tt1[{i1.dut_b, i1.dut_a}];

    gate_tt_checker #(.SETTLE(S0), .EXPECT(E0)) u_dut0 (.clk(clk), .reset(reset), .bus(i0.slave));
    gate_tt_checker #(.SETTLE(S1), .EXPECT(E1)) u_dut1 (.clk(clk), .reset(reset), .bus(i1.slave));

    // {dut_b, dut_a, busy, done, pass, fail_count[2:0], fail_mask[3:0]}
    logic [11:0] act0, act1;
    assign act0 = {i0.dut_b, i0.dut_a, i0.busy, i0.done, i0.pass, i0.fail_count, i0.fail_mask};
    assign act1 = {i1.dut_b, i1.dut_a, i1.busy, i1.done, i1.pass, i1.fail_count, i1.fail_mask};

    // Model: t = edges since the start edge; vector k occupies t in
    // [k*(S+1), (k+1)*(S+1)) and its result is visible once t >= (k+1)*(S+1).
    typedef struct packed {
        logic       running;
        logic       done;
        logic [7:0] t;
        logic [3:0] full;
    } model_t;

    model_t m0, m1;
    logic   chk_en = 1'b0;
    int     checks = 0;
    int     errors = 0;

    function automatic model_t step(model_t m, logic rst, logic st, logic [3:0] tt, int s, logic [3:0] e);
        model_t n = m;
        if (rst)
            n = '0;
        else if (!m.running && st) begin
            n.running = 1'b1;
            n.done    = 1'b0;
            n.t       = 8'd0;
            n.full    = tt ^ e;
        end else if (m.running) begin
            n.t = m.t + 8'd1;
            if (int'(n.t) == 4 * (s + 1)) begin
                n.running = 1'b0;
                n.done    = 1'b1;
            end
        end
        return n;
    endfunction

    function automatic logic [11:0] expect_out(model_t m, int s);
        int         k;
        logic [4:0] lm;
        logic [3:0] mask;
        logic [1:0] idx;
        logic [2:0] cnt;
        idx  = 2'd0;
        mask = 4'd0;
        if (m.running) begin
            k    = int'(m.t) / (s + 1);
            idx  = 2'(k);
            lm   = (5'd1 << k) - 5'd1;
            mask = m.full & lm[3:0];
        end else if (m.done) begin
            idx  = 2'd3;
            mask = m.full;
        end
        cnt = 3'($countones(mask));
        return {idx[1], idx[0], m.running, m.done, m.done && (cnt == 3'd0), cnt, mask};
    endfunction

    task automatic chk(input string name, input logic [11:0] got, input logic [11:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    always @(posedge clk) begin
        m0     <= step(m0, reset, i0.start, tt0, S0, E0);
        m1     <= step(m1, reset, i1.start, tt1, S1, E1);
        chk_en <= chk_en | reset;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model0", act0, expect_out(m0, S0));
            chk("model1", act1, expect_out(m1, S1));
        end
    end

    // Pulse start on dut0 and wait for done; captures {b,a} at a few points.
    task automatic run0(output int n, output logic [1:0] ab0, output logic [1:0] ab4,
                        output logic [1:0] ab5, output logic [1:0] ab10, output logic [1:0] ab15);
        @(negedge clk); i0.start = 1'b1;
        @(negedge clk); i0.start = 1'b0;
        n = 0; ab0 = {i0.dut_b, i0.dut_a};
        ab4 = 2'bxx; ab5 = 2'bxx; ab10 = 2'bxx; ab15 = 2'bxx;
        while (!i0.done && n < 100) begin
            @(negedge clk);
            n++;
            case (n)
                4:  ab4  = {i0.dut_b, i0.dut_a};
                5:  ab5  = {i0.dut_b, i0.dut_a};
                10: ab10 = {i0.dut_b, i0.dut_a};
                15: ab15 = {i0.dut_b, i0.dut_a};
                default: ;
            endcase
        end
    endtask

    int         lat;
    logic [1:0] a0, a4, a5, a10, a15;

    initial begin
        reset = 1'b1; i0.start = 1'b0; i1.start = 1'b0;
        tt0 = TT_NAND; tt1 = TT_XOR;
        repeat (2) @(negedge clk);
        chk("reset0", act0, 12'h000);
        chk("reset1", act1, 12'h000);
        reset = 1'b0;

        // Correct NAND loopback
        run0(lat, a0, a4, a5, a10, a15);
        chk("nand_lat", 12'(lat), 12'd20);
        chk("nand_res", {i0.pass, i0.fail_count, i0.fail_mask}, {1'b1, 3'd0, 4'b0000});
        chk("nand_ab0", {10'd0, a0}, {10'd0, 2'b00});
        chk("nand_ab4", {10'd0, a4}, {10'd0, 2'b00});
        chk("nand_ab5", {10'd0, a5}, {10'd0, 2'b01});
        chk("nand_ab10", {10'd0, a10}, {10'd0, 2'b10});
        chk("nand_ab15", {10'd0, a15}, {10'd0, 2'b11});

        // Gate disagrees with EXPECT on every vector
        tt0 = TT_AND;
        run0(lat, a0, a4, a5, a10, a15);
        chk("wrong_lat", 12'(lat), 12'd20);
        chk("wrong_res", {i0.pass, i0.fail_count, i0.fail_mask}, {1'b0, 3'd4, 4'b1111});

        // Output tied high, run twice
        tt0 = 4'b1111;
        run0(lat, a0, a4, a5, a10, a15);
        chk("tied1_res", {i0.pass, i0.fail_count, i0.fail_mask}, {1'b0, 3'd1, 4'b1000});
        run0(lat, a0, a4, a5, a10, a15);
        chk("tied1_res2", {i0.pass, i0.fail_count, i0.fail_mask}, {1'b0, 3'd1, 4'b1000});

        // Reset during vector 2 settle
        tt0 = TT_NAND;
        @(negedge clk); i0.start = 1'b1;
        @(negedge clk); i0.start = 1'b0;
        repeat (11) @(negedge clk);
        chk("mid_idx2", {10'd0, i0.dut_b, i0.dut_a}, {10'd0, 2'b10});
        reset = 1'b1;
        @(negedge clk);
        chk("mid_reset", act0, 12'h000);
        reset = 1'b0;
        run0(lat, a0, a4, a5, a10, a15);
        chk("post_reset_lat", 12'(lat), 12'd20);
        chk("post_reset_res", {i0.pass, i0.fail_count, i0.fail_mask}, {1'b1, 3'd0, 4'b0000});

        // SETTLE=1 XOR with start pulses while busy
        @(negedge clk); i1.start = 1'b1;
        @(negedge clk); i1.start = 1'b0;
        lat = 0;
        while (!i1.done && lat < 100) begin
            @(negedge clk);
            lat++;
            i1.start = (lat <= 5);
        end
        i1.start = 1'b0;
        chk("xor_lat", 12'(lat), 12'd8);
        chk("xor_res", {i1.pass, i1.fail_count, i1.fail_mask}, {1'b1, 3'd0, 4'b0000});

        // Random tables, starts and resets; gate only changes between runs
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 59) == 0);
            if (!m0.running) tt0 = 4'($urandom);
            if (!m1.running) tt1 = 4'($urandom);
            i0.start = ($urandom_range(0, 3) == 0);
            i1.start = ($urandom_range(0, 3) == 0);
        end
        @(negedge clk);
        reset = 1'b0; i0.start = 1'b0; i1.start = 1'b0;
        repeat (30) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
